usb_wire_access_sched: RTL
==========================

Name: usb_wire_access_sched

Overview:
- Schedules ownership of the shared USB differential wire between three transmit requesters: SOF generator, packet transmitter, and line-control (bus reset/resume signalling).
- Drives TxWireActiveDrive and noActivityTimeOutEnable into the wire receive/clock-recovery datapath.
- Enforces an inter-packet idle gap and sequences the response-wait window after a packet that expects a reply.
- Sits between the SIE transmit processes and the wire RX/TX engines.

Parameters:
- FS_GAP_CLKS, 8, idle clocks enforced after any wire activity at full speed.
- LS_GAP_CLKS, 64, idle clocks enforced after any wire activity at low speed.
- GAP_CNT_W, 8, gap counter width; must hold max(FS_GAP_CLKS, LS_GAP_CLKS).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- fullSpeedRate  in  1  1 = full-speed gap, 0 = low-speed gap.
- sofReq  in  1  SOF transmit request (level, held until granted).
- sofGnt  out  1  SOF owns wire.
- sofDone  in  1  one-cycle pulse, SOF transmission finished.
- pktReq  in  1  packet transmit request.
- pktRespExp  in  1  sampled with pktReq at grant: 1 = response expected.
- pktGnt  out  1  packet transmitter owns wire.
- pktDone  in  1  one-cycle pulse, packet finished.
- sofNear  in  1  1 blocks new pktGnt (SOF imminent); does not affect sof/line.
- lineReq  in  1  line-control request.
- lineGnt  out  1  line control owns wire.
- lineDone  in  1  one-cycle pulse, line signalling finished.
- TxWireActiveDrive  out  1  1 while any transmit grant is active.
- noActivityTimeOutEnable  out  1  1 only in RESP_WAIT.
- noActivityTimeOut  in  1  pulse from RX datapath: response timeout expired.
- RxWireActive  in  1  RX datapath reports an incoming packet.
- respStart  out  1  one-cycle pulse: response detected.
- respTimeOut  out  1  one-cycle pulse: no response within timeout.

Behaviour:
- All outputs are registered. Reset value of every output is 0. State resets to IDLE; gap counter resets to 0.
- States: IDLE, SOF_TX, PKT_TX, LINE_TX, RESP_WAIT, RESP_RX, GAP.
- IDLE: fixed priority lineReq > sofReq > (pktReq & !sofNear).
  - Grant and TxWireActiveDrive assert on the clock edge after the request is seen (latency 1).
  - pktRespExp is latched into respExpReg at the pkt grant.
- SOF_TX / LINE_TX: hold the grant until the matching Done pulse, then deassert the grant and TxWireActiveDrive on the next edge and enter GAP.
- PKT_TX: on pktDone, deassert pktGnt and TxWireActiveDrive.
  - If respExpReg = 1, go to RESP_WAIT; otherwise go to GAP.
- RESP_WAIT: noActivityTimeOutEnable = 1.
  - RxWireActive = 1: pulse respStart, enable <= 0, go to RESP_RX.
  - noActivityTimeOut = 1 (with RxWireActive = 0): pulse respTimeOut, enable <= 0, go to GAP.
  - If both are seen in the same cycle, RxWireActive wins: respStart pulses, respTimeOut does not.
  - lineReq = 1 preempts: abort with no pulse, grant lineGnt directly next edge without a gap.
- RESP_RX: wait for RxWireActive = 0, then go to GAP. lineReq preempts exactly as in RESP_WAIT.
- GAP: on entry, load FS_GAP_CLKS-1 or LS_GAP_CLKS-1 according to fullSpeedRate at entry.
  - Decrement each clock; leave for IDLE when the count is 0.
  - Requests arriving during GAP are held pending (requesters keep them asserted).
  - A Done pulse arriving outside the matching TX state is ignored.
- A Done pulse and a new request in the same cycle: the Done is processed first (GAP entered); no back-to-back grant.
- At most one grant is high at any time; the grant outputs are mutually exclusive.
- Reset mid-operation: asynchronous return to IDLE with all outputs 0 immediately; no pending pulse is emitted afterwards.

Decomposition:
- Shared package: state encodings (3-bit) and default FS/LS gap clock constants, alongside the existing over-sample/timeout defines.
- One sub-module: usb_wire_gap_timer.
  - Interface: load, fullSpeedRate, expired.
  - Contains the gap down-counter and speed select.

Test Plan:
- sofReq and pktReq rise in the same cycle from IDLE → sofGnt = 1 after 1 clk, pktGnt stays 0. After sofDone, exactly 8 idle clks (FS), then pktGnt = 1.
- pktReq with pktRespExp = 1, pktDone, RxWireActive rises 20 clks later → noActivityTimeOutEnable high for those 20 clks, respStart single pulse, enable 0. After RxWireActive falls, 8-clk gap.
- Same as above but noActivityTimeOut pulses instead → respTimeOut single pulse, no respStart, GAP entered.
- fullSpeedRate = 0, lineReq granted then lineDone → 64-clk gap before any new grant; sofNear = 1 with pktReq pending → pktGnt never asserts until sofNear = 0.
- In RESP_WAIT, assert lineReq → lineGnt = 1 next edge, no respTimeOut/respStart, enable 0.
- Assert rst during PKT_TX → pktGnt, TxWireActiveDrive, and all outputs drop to 0 without waiting for a clk edge; after release, a new sofReq is granted with latency 1.

Source files
------------

// File: rtl/usb_wire_access_sched_pkg.sv
// Shared definitions for the USB wire access scheduler.
//   - schedState_t : 3-bit scheduler state encoding
//   - FS/LS gap defaults : idle clocks enforced after wire activity
//   - over-sample / timeout constants used by the wire RX/TX engines
package usb_wire_access_sched_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SOF_TX    = 3'd1,
    PKT_TX    = 3'd2,
    LINE_TX   = 3'd3,
    RESP_WAIT = 3'd4,
    RESP_RX   = 3'd5,
    GAP       = 3'd6
  } schedState_t;

  localparam int FS_GAP_CLKS_DEF = 8;
  localparam int LS_GAP_CLKS_DEF = 64;

  localparam int FS_OVERSAMPLE      = 4;
  localparam int LS_OVERSAMPLE      = 32;
  localparam int RESP_TIMEOUT_CLKS  = 18 * FS_OVERSAMPLE;

endpackage

// File: rtl/usb_wire_gap_timer.sv
// Inter-packet idle gap timer.
// Down-counter loaded with (gap length - 1) for the selected bus speed;
// expired is high whenever the count has reached zero.
// Ports:
//   clk, rst       : clock, async active-high reset
//   load           : reload the counter this edge
//   fullSpeedRate  : 1 = full-speed gap length, 0 = low-speed gap length
//   expired        : terminal count reached
module usb_wire_gap_timer
  import usb_wire_access_sched_pkg::*;
#(
  parameter int FS_GAP_CLKS = FS_GAP_CLKS_DEF,
  parameter int LS_GAP_CLKS = LS_GAP_CLKS_DEF,
  parameter int GAP_CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic fullSpeedRate,
  output logic expired
);

  logic [GAP_CNT_W-1:0] gapCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gapCnt <= '0;
    end else if (load) begin
      gapCnt <= fullSpeedRate ? GAP_CNT_W'(FS_GAP_CLKS - 1) : GAP_CNT_W'(LS_GAP_CLKS - 1);
    end else if (gapCnt != '0) begin
      gapCnt <= gapCnt - 1'b1;
    end
  end

  assign expired = (gapCnt == '0);

endmodule

// File: rtl/usb_wire_access_sched.sv
// USB wire access scheduler: arbitrates the shared differential wire between
// the SOF generator, the packet transmitter and line control, enforces the
// inter-packet idle gap and sequences the response-wait window.
// Ports:
//   clk, rst                          : clock, async active-high reset
//   fullSpeedRate                     : gap length select (1 = FS, 0 = LS)
//   sofReq/sofGnt/sofDone             : SOF requester handshake
//   pktReq/pktRespExp/pktGnt/pktDone  : packet requester handshake
//   sofNear                           : blocks new packet grants
//   lineReq/lineGnt/lineDone          : line-control requester handshake
//   TxWireActiveDrive                 : any transmit grant active
//   noActivityTimeOutEnable           : response timeout armed
//   noActivityTimeOut, RxWireActive   : status from the RX datapath
//   respStart, respTimeOut            : response outcome pulses
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | wire free, arbitrating line > sof > pkt
// SOF_TX    | SOF generator owns the wire
// PKT_TX    | packet transmitter owns the wire
// LINE_TX   | line control owns the wire
// RESP_WAIT | waiting for a reply, timeout armed
// RESP_RX   | reply being received
// GAP       | enforced idle gap after wire activity
module usb_wire_access_sched
  import usb_wire_access_sched_pkg::*;
#(
  parameter int FS_GAP_CLKS = FS_GAP_CLKS_DEF,
  parameter int LS_GAP_CLKS = LS_GAP_CLKS_DEF,
  parameter int GAP_CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic fullSpeedRate,
  input  logic sofReq,
  output logic sofGnt,
  input  logic sofDone,
  input  logic pktReq,
  input  logic pktRespExp,
  output logic pktGnt,
  input  logic pktDone,
  input  logic sofNear,
  input  logic lineReq,
  output logic lineGnt,
  input  logic lineDone,
  output logic TxWireActiveDrive,
  output logic noActivityTimeOutEnable,
  input  logic noActivityTimeOut,
  input  logic RxWireActive,
  output logic respStart,
  output logic respTimeOut
);

  schedState_t state;
  logic        respExpReg;
  logic        gapLoad;
  logic        gapExpired;

  // The timer must reload on the same edge that enters GAP so the gap
  // length counts from the first GAP clock; these are exactly the
  // FSM's transitions into GAP below.
  always_comb begin
    gapLoad = 1'b0;
    case (state)
      SOF_TX:    gapLoad = sofDone;
      LINE_TX:   gapLoad = lineDone;
      PKT_TX:    gapLoad = pktDone & ~respExpReg;
      RESP_WAIT: gapLoad = ~lineReq & ~RxWireActive & noActivityTimeOut;
      RESP_RX:   gapLoad = ~lineReq & ~RxWireActive;
      default:   gapLoad = 1'b0;
    endcase
  end

  usb_wire_gap_timer #(
    .FS_GAP_CLKS (FS_GAP_CLKS),
    .LS_GAP_CLKS (LS_GAP_CLKS),
    .GAP_CNT_W   (GAP_CNT_W)
  ) u_gapTimer (
    .clk           (clk),
    .rst           (rst),
    .load          (gapLoad),
    .fullSpeedRate (fullSpeedRate),
    .expired       (gapExpired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                   <= IDLE;
      respExpReg              <= 1'b0;
      sofGnt                  <= 1'b0;
      pktGnt                  <= 1'b0;
      lineGnt                 <= 1'b0;
      TxWireActiveDrive       <= 1'b0;
      noActivityTimeOutEnable <= 1'b0;
      respStart               <= 1'b0;
      respTimeOut             <= 1'b0;
    end else begin
      respStart   <= 1'b0;
      respTimeOut <= 1'b0;
      case (state)
        IDLE: begin
          if (lineReq) begin
            state             <= LINE_TX;
            lineGnt           <= 1'b1;
            TxWireActiveDrive <= 1'b1;
          end else if (sofReq) begin
            state             <= SOF_TX;
            sofGnt            <= 1'b1;
            TxWireActiveDrive <= 1'b1;
          end else if (pktReq && !sofNear) begin
            state             <= PKT_TX;
            pktGnt            <= 1'b1;
            TxWireActiveDrive <= 1'b1;
            respExpReg        <= pktRespExp;
          end
        end
        SOF_TX: begin
          if (sofDone) begin
            state             <= GAP;
            sofGnt            <= 1'b0;
            TxWireActiveDrive <= 1'b0;
          end
        end
        LINE_TX: begin
          if (lineDone) begin
            state             <= GAP;
            lineGnt           <= 1'b0;
            TxWireActiveDrive <= 1'b0;
          end
        end
        PKT_TX: begin
          if (pktDone) begin
            pktGnt            <= 1'b0;
            TxWireActiveDrive <= 1'b0;
            if (respExpReg) begin
              state                   <= RESP_WAIT;
              noActivityTimeOutEnable <= 1'b1;
            end else begin
              state <= GAP;
            end
          end
        end
        RESP_WAIT: begin
          // Line control may abort the response window; no outcome pulse
          // and no gap, the wire goes straight to line signalling.
          if (lineReq) begin
            state                   <= LINE_TX;
            lineGnt                 <= 1'b1;
            TxWireActiveDrive       <= 1'b1;
            noActivityTimeOutEnable <= 1'b0;
          end else if (RxWireActive) begin
            state                   <= RESP_RX;
            respStart               <= 1'b1;
            noActivityTimeOutEnable <= 1'b0;
          end else if (noActivityTimeOut) begin
            state                   <= GAP;
            respTimeOut             <= 1'b1;
            noActivityTimeOutEnable <= 1'b0;
          end
        end
        RESP_RX: begin
          if (lineReq) begin
            state             <= LINE_TX;
            lineGnt           <= 1'b1;
            TxWireActiveDrive <= 1'b1;
          end else if (!RxWireActive) begin
            state <= GAP;
          end
        end
        GAP: begin
          if (gapExpired) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
